fetch_exec_sequencer: RTL and testbench
=======================================

Name: fetch_exec_sequencer

Overview:
Multi-cycle control unit for the 9-bit core. Owns the PC and fetches from instruction memory. Classifies each instruction the same way the field decoder does, then sequences one of three paths: register write-back, branch resolution through a 16-entry jump-target LUT, or a data-memory request/acknowledge handshake. Sits between imem, the decoder/register file, and dmem.

Parameters:
PC_W, 10, width of PC, imem address and LUT entries
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begins execution at start_pc (ignored unless IDLE or DONE)
start_pc  in  PC_W  initial PC sampled with start
imem_addr  out  PC_W  instruction address (equals pc)
instr  in  9  imem read data, valid the cycle after imem_addr is presented
flag_gt  in  1  greater-than flag from last cmp
flag_eq  in  1  equal flag from last cmp
lut_we  in  1  jump-LUT write enable
lut_waddr  in  4  jump-LUT write index
lut_wdata  in  PC_W  jump-LUT write data (absolute target)
reg_we  out  1  one-cycle register-file write strobe
mem_req  out  1  dmem request, held until mem_ack
mem_we  out  1  1 = store, valid while mem_req
mem_ack  in  1  dmem completion
pc  out  PC_W  current PC
busy  out  1  high in FETCH/EXEC/MEM_WAIT
done  out  1  high in DONE
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async): state IDLE, pc=0, retired=0, all LUT entries 0. reg_we, mem_req, mem_we, busy and done all 0.
- IDLE: on start, pc<=start_pc, retired<=0, go to FETCH.
- FETCH (1 cycle): imem_addr=pc; go to EXEC.
- EXEC: instr is valid; classify with casez in priority order:
  - 9'h1FF: halt -> DONE. pc unchanged; retired increments.
  - 1000?????: conditional branch. instr[4]=0 is jg (taken if flag_gt). instr[4]=1 is jge (taken if flag_gt|flag_eq).
  - 10010????: jmp, always taken.
  - Taken branch: pc<=lut[instr[3:0]]. Not taken: pc<=pc+1.
  - 10111???? (ldr/str) or 11000???? (ldi/sti): memory op. mem_req=1, mem_we=instr[3].
    - If mem_ack in the same cycle: complete now.
    - Otherwise go to MEM_WAIT.
  - 00???????, 01???????, 1010?????, 10110????: reg_we=1, pc<=pc+1.
  - Anything else: no-op, pc<=pc+1.
  - Every non-memory path returns to FETCH (except halt -> DONE) and increments retired.
- MEM_WAIT: hold mem_req=1 and mem_we, both taken from a registered copy of instr (instr need not stay stable). On mem_ack: pulse reg_we if load (mem_we=0), pc<=pc+1, retired+1, go to FETCH.
- Memory completion in EXEC behaves identically: reg_we only for loads.
- Latency: 2 cycles per non-memory instruction. Memory instruction takes 2 + N cycles, where N = wait cycles before ack.
- PC arithmetic is modulo 2^PC_W; wrap from all-ones to 0 is silent.
- retired wraps modulo 2^CNT_W.
- DONE: done=1, busy=0. start restarts exactly as from IDLE.
- start while busy is ignored.
- mem_ack outside EXEC/MEM_WAIT is ignored.
- LUT write: synchronous, allowed in any state. A same-cycle read of the written index in EXEC returns the old value.
- Reset asserted mid-operation (including with mem_req high): immediate return to reset values, and mem_req drops asynchronously.
- reg_we and mem_req are never high in the same cycle.

Decomposition:
- Shared package holds:
  - state enum (IDLE, FETCH, EXEC, MEM_WAIT, DONE)
  - opcode-class casez constants: HALT_OP, JCOND_PAT, JMP_PAT, LDST_PAT, LDISTI_PAT
  - class enum (ALU, JCOND, JMP, MEM, HALT, NOP)
- One sub-module, jump_lut: a 16 x PC_W register array with async reset, a synchronous write port and a combinational read port.

Test Plan:
- Reset, start, ALU ops: reset, start with start_pc=5, feed instr=9'h00A at pc 5,6 -> imem_addr 5,6,7 on 2-cycle spacing; reg_we pulses in each EXEC; retired=2.
- jg taken vs not taken: LUT[3]=40, instr=9'b100000011. With flag_gt=1 -> next pc=40. With flag_gt=0, flag_eq=1 -> pc+1. Repeat as jge (9'b100010011) with flag_eq=1 -> pc=40.
- jmp with LUT written same cycle: LUT[7]=12; in the EXEC of jmp 9'b100100111, write lut[7]=99 -> pc=12, not 99. A later jmp to index 7 -> pc=99.
- Load with 3 wait cycles: instr=9'b101110010, mem_ack asserted 3 cycles after EXEC -> mem_req high 4 cycles, mem_we=0, single reg_we on the ack cycle, pc+1.
- Store with zero-wait ack: instr=9'b110001000, mem_ack=1 in EXEC -> mem_req/mem_we high 1 cycle, no reg_we. Then instr=9'h1FF -> done=1, busy=0, pc held; a start pulse restarts at new start_pc.
- Wrap and mid-op reset: start_pc=1023, ALU op -> next pc=0. During MEM_WAIT assert reset -> mem_req=0 immediately; state IDLE, pc=0, retired=0, LUT cleared.

Source files
------------

// File: rtl/fetch_exec_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: FSM encodings, opcode-class
// patterns and the instruction classifier shared with the field decoder.
package fetch_exec_sequencer_pkg;

  localparam int unsigned LutDepth = 16;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StExec    = 3'd2;
  localparam logic [2:0] StMemWait = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam logic [8:0] HALT_OP    = 9'h1FF;
  localparam logic [8:0] JCOND_PAT  = 9'b1000?????;
  localparam logic [8:0] JMP_PAT    = 9'b10010????;
  localparam logic [8:0] LDST_PAT   = 9'b10111????;
  localparam logic [8:0] LDISTI_PAT = 9'b11000????;
  localparam logic [8:0] ALU0_PAT   = 9'b00???????;
  localparam logic [8:0] ALU1_PAT   = 9'b01???????;
  localparam logic [8:0] ALU2_PAT   = 9'b1010?????;
  localparam logic [8:0] ALU3_PAT   = 9'b10110????;

  typedef enum logic [2:0] {ClsAlu, ClsJcond, ClsJmp, ClsMem, ClsHalt, ClsNop} op_class_e;

  // Priority order matters: halt is checked before any other pattern.
  function automatic op_class_e classify(input logic [8:0] instr);
    casez (instr)
      HALT_OP:                                return ClsHalt;
      JCOND_PAT:                              return ClsJcond;
      JMP_PAT:                                return ClsJmp;
      LDST_PAT, LDISTI_PAT:                   return ClsMem;
      ALU0_PAT, ALU1_PAT, ALU2_PAT, ALU3_PAT: return ClsAlu;
      default:                                return ClsNop;
    endcase
  endfunction

endpackage

// File: rtl/fetch_exec_sequencer_if.sv
// Bus bundle between the sequencer and its imem, decoder/register file and dmem.
interface fetch_exec_sequencer_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [PC_W-1:0]  start_pc;
  logic [PC_W-1:0]  imem_addr;
  logic [8:0]       instr;
  logic             flag_gt;
  logic             flag_eq;
  logic             lut_we;
  logic [3:0]       lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic             reg_we;
  logic             mem_req;
  logic             mem_we;
  logic             mem_ack;
  logic [PC_W-1:0]  pc;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, start_pc, instr, flag_gt, flag_eq, lut_we, lut_waddr, lut_wdata, mem_ack,
    input  imem_addr, reg_we, mem_req, mem_we, pc, busy, done, retired
  );

  modport slave (
    input  start, start_pc, instr, flag_gt, flag_eq, lut_we, lut_waddr, lut_wdata, mem_ack,
    output imem_addr, reg_we, mem_req, mem_we, pc, busy, done, retired
  );
endinterface

// File: rtl/fetch_exec_sequencer_jump_lut.sv
// 16-entry jump-target table: async-reset registers, synchronous write, combinational read.
module jump_lut
  import fetch_exec_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we_i,
  input  logic [3:0]      waddr_i,
  input  logic [PC_W-1:0] wdata_i,
  input  logic [3:0]      raddr_i,
  output logic [PC_W-1:0] rdata_o
);

  logic [PC_W-1:0] mem_q [LutDepth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LutDepth; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/execute control: owns the PC, sequences ALU write-back,
// LUT-based branches and the dmem request/acknowledge handshake.
module fetch_exec_sequencer
  import fetch_exec_sequencer_pkg::*;
#(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  fetch_exec_sequencer_if.slave bus
);

  logic [2:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_we_q, mem_we_d;
  logic             reg_we, mem_req, mem_we, taken;
  logic [PC_W-1:0]  lut_rdata, pc_inc;
  logic [CNT_W-1:0] retired_inc;
  op_class_e        op_class;

  jump_lut #(.PC_W(PC_W)) u_jump_lut (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bus.lut_we),
    .waddr_i (bus.lut_waddr),
    .wdata_i (bus.lut_wdata),
    .raddr_i (bus.instr[3:0]),
    .rdata_o (lut_rdata)
  );

  assign op_class    = classify(bus.instr);
  assign pc_inc      = pc_q + PC_W'(1);
  assign retired_inc = retired_q + CNT_W'(1);
  assign taken       = (op_class == ClsJmp) ||
                       (bus.instr[4] ? (bus.flag_gt | bus.flag_eq) : bus.flag_gt);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    mem_we_d  = mem_we_q;
    reg_we    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          pc_d      = bus.start_pc;
          retired_d = '0;
          state_d   = StFetch;
        end
      end
      StFetch: state_d = StExec;
      StExec: begin
        retired_d = retired_inc;
        pc_d      = pc_inc;
        state_d   = StFetch;
        case (op_class)
          ClsHalt: begin
            pc_d    = pc_q;
            state_d = StDone;
          end
          ClsJcond, ClsJmp: if (taken) pc_d = lut_rdata;
          ClsAlu:           reg_we = 1'b1;
          ClsMem: begin
            mem_req = 1'b1;
            mem_we  = bus.instr[3];
            if (bus.mem_ack) begin
              reg_we = ~bus.instr[3];
            end else begin
              // Hold completion; instr may change, so keep the store bit locally.
              mem_we_d  = bus.instr[3];
              pc_d      = pc_q;
              retired_d = retired_q;
              state_d   = StMemWait;
            end
          end
          default: ;
        endcase
      end
      StMemWait: begin
        mem_req = 1'b1;
        mem_we  = mem_we_q;
        if (bus.mem_ack) begin
          reg_we    = ~mem_we_q;
          pc_d      = pc_inc;
          retired_d = retired_inc;
          state_d   = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      retired_q <= '0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      mem_we_q  <= mem_we_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.retired   = retired_q;
  assign bus.reg_we    = reg_we;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.busy      = (state_q == StFetch) || (state_q == StExec) || (state_q == StMemWait);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed plus randomized bench for fetch_exec_sequencer against a per-instruction
// reference model (pc, retired count and jump table as plain integers).
module tb_fetch_exec_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_pc = 0;
  int   m_ret = 0;
  int   m_lut [16];

  fetch_exec_sequencer_if bus ();

  fetch_exec_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_ret = 0;
    for (int i = 0; i < 16; i++) m_lut[i] = 0;
  endtask

  task automatic do_start(input int spc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_pc = spc[9:0];
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    m_pc = spc % 1024;
    m_ret = 0;
  endtask

  task automatic lut_write(input int idx, input int data);
    @(negedge clk);
    bus.lut_we = 1'b1;
    bus.lut_waddr = idx[3:0];
    bus.lut_wdata = data[9:0];
    @(posedge clk);
    #1;
    bus.lut_we = 1'b0;
    m_lut[idx] = data;
  endtask

  // One instruction from FETCH through completion; optional LUT write during EXEC.
  task automatic exec_instr(input logic [8:0] ins, input bit gt, input bit eq, input int waitn,
                            input bit wr, input int widx, input int wdata);
    bit halt, jc, jmp, memop, alu, load, taken;
    int nxt;
    halt  = (ins == 9'h1FF);
    jc    = (ins[8:5] == 4'b1000);
    jmp   = (ins[8:4] == 5'b10010);
    memop = (ins[8:4] == 5'b10111) || (ins[8:4] == 5'b11000);
    alu   = !halt && (!ins[8] || ins[8:5] == 4'b1010 || ins[8:4] == 5'b10110);
    load  = memop && !ins[3];
    taken = jmp || (jc && (ins[4] ? (gt || eq) : gt));
    nxt   = halt ? m_pc : (taken ? m_lut[ins[3:0]] : (m_pc + 1) % 1024);

    @(negedge clk);  // FETCH: start and mem_ack must be ignored here
    bus.start = 1'($urandom_range(0, 1));
    bus.start_pc = 10'($urandom);
    bus.mem_ack = 1'($urandom_range(0, 1));
    bus.instr = 9'($urandom);
    #1;
    chk("fetch_busy", 32'(bus.busy), 1);
    chk("fetch_addr", 32'(bus.imem_addr), m_pc);
    chk("fetch_pc", 32'(bus.pc), m_pc);
    chk("fetch_retired", 32'(bus.retired), m_ret);
    chk("fetch_strobes", 32'({bus.reg_we, bus.mem_req}), 0);

    @(negedge clk);  // EXEC
    bus.start = 1'b0;
    bus.instr = ins;
    bus.flag_gt = gt;
    bus.flag_eq = eq;
    bus.mem_ack = memop && (waitn == 0);
    bus.lut_we = wr;
    bus.lut_waddr = widx[3:0];
    bus.lut_wdata = wdata[9:0];
    #1;
    chk("exec_addr", 32'(bus.imem_addr), m_pc);
    chk("exec_reg_we", 32'(bus.reg_we), 32'(alu || (load && waitn == 0)));
    chk("exec_mem_req", 32'(bus.mem_req), 32'(memop));
    if (memop) chk("exec_mem_we", 32'(bus.mem_we), 32'(ins[3]));

    if (memop) begin
      for (int k = 1; k <= waitn; k++) begin
        @(negedge clk);
        bus.lut_we = 1'b0;
        bus.instr = 9'($urandom);
        bus.mem_ack = (k == waitn);
        #1;
        chk("wait_mem_req", 32'(bus.mem_req), 1);
        chk("wait_mem_we", 32'(bus.mem_we), 32'(ins[3]));
        chk("wait_reg_we", 32'(bus.reg_we), 32'(load && k == waitn));
      end
    end
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    bus.lut_we = 1'b0;
    if (wr) m_lut[widx] = wdata;
    m_pc = nxt;
    m_ret = (m_ret + 1) % 65536;

    if (halt) begin
      @(negedge clk);
      #1;
      chk("done_done", 32'(bus.done), 1);
      chk("done_busy", 32'(bus.busy), 0);
      chk("done_pc", 32'(bus.pc), m_pc);
      chk("done_retired", 32'(bus.retired), m_ret);
    end
  endtask

  initial begin
    logic [8:0] ins;
    bus.start = 1'b0;
    bus.start_pc = '0;
    bus.instr = '0;
    bus.flag_gt = 1'b0;
    bus.flag_eq = 1'b0;
    bus.lut_we = 1'b0;
    bus.lut_waddr = '0;
    bus.lut_wdata = '0;
    bus.mem_ack = 1'b0;
    model_reset();

    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_retired", 32'(bus.retired), 0);
    chk("rst_strobes", 32'({bus.reg_we, bus.mem_req, bus.mem_we}), 0);
    @(negedge clk);
    reset = 1'b0;

    // ALU ops from pc 5, then halt
    do_start(5);
    exec_instr(9'h00A, 0, 0, 0, 0, 0, 0);
    exec_instr(9'h00A, 0, 0, 0, 0, 0, 0);
    exec_instr(9'h1FF, 0, 0, 0, 0, 0, 0);

    // Branches, same-cycle LUT write, memory handshakes
    lut_write(3, 40);
    lut_write(7, 12);
    do_start(100);
    exec_instr(9'b100000011, 1, 0, 0, 0, 0, 0);
    exec_instr(9'b100000011, 0, 1, 0, 0, 0, 0);
    exec_instr(9'b100010011, 0, 1, 0, 0, 0, 0);
    exec_instr(9'b100100111, 0, 0, 0, 1, 7, 99);
    exec_instr(9'b100100111, 0, 0, 0, 0, 0, 0);
    exec_instr(9'b101110010, 0, 0, 3, 0, 0, 0);
    exec_instr(9'b110001000, 0, 0, 0, 0, 0, 0);
    exec_instr(9'h1FF, 0, 0, 0, 0, 0, 0);

    // PC wrap, then reset in MEM_WAIT
    do_start(1023);
    exec_instr(9'h055, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("wrap_fetch_pc", 32'(bus.pc), 0);
    @(negedge clk);
    bus.instr = 9'b101110010;
    bus.mem_ack = 1'b0;
    #1;
    chk("midrst_exec_req", 32'(bus.mem_req), 1);
    @(negedge clk);
    bus.instr = 9'($urandom);
    #1;
    chk("midrst_wait_req", 32'(bus.mem_req), 1);
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_mem_req", 32'(bus.mem_req), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_pc", 32'(bus.pc), 0);
    chk("midrst_retired", 32'(bus.retired), 0);
    @(negedge clk);
    reset = 1'b0;

    // Cleared LUT: jump through entry 3 lands on 0
    do_start(50);
    exec_instr(9'b100100011, 0, 0, 0, 0, 0, 0);

    // Randomized run
    for (int n = 0; n < 40; n++) begin
      ins = 9'($urandom);
      if (ins == 9'h1FF) ins = 9'h000;
      exec_instr(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 1023)));
    end
    exec_instr(9'h1FF, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
